// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC controller: state encoding and
// default PC geometry.
package pc_ctrl_pkg;

  localparam int PC_W = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int DEF_INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_pc.sv
// Program counter register; loads pc_in every cycle and returns to the reset
// vector on a synchronous reset.
module pc_ctrl_pc #(
  parameter int                     W            = 32,
  parameter logic [W-1:0]           RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pc_in,
  output logic [W-1:0] pc_q
);

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VECTOR;
    else     pc_q <= pc_in;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage controller: sequences the PC through advance, stall hold,
// branch redirect and slow-imem waits, and drives fetch/flush/valid strobes.
//
//   state | meaning
//   BOOT  | first cycle out of reset, no fetch issued, pc = reset vector
//   RUN   | normal fetch; pc advances when imem returns and nothing stalls
//   REDIR | redirect pending in tgt_q; waiting for imem to drop old fetch
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                           PC_WIDTH_LENGTH = PC_W,
  parameter logic [PC_WIDTH_LENGTH-1:0]   RESET_VECTOR    = PC_WIDTH_LENGTH'(DEF_RESET_VECTOR),
  parameter int                           INSTR_BYTES     = DEF_INSTR_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       br_taken,
  input  logic [PC_WIDTH_LENGTH-1:0] br_target,
  input  logic                       imem_ready,
  output logic [PC_WIDTH_LENGTH-1:0] pc_out,
  output logic                       fetch_req,
  output logic                       if_valid,
  output logic                       flush_ifid,
  output logic                       flush_idex,
  output logic                       br_misalign
);

  pc_state_t                  state;
  logic [PC_WIDTH_LENGTH-1:0] tgt_q;
  logic [PC_WIDTH_LENGTH-1:0] tgt_aligned;
  logic [PC_WIDTH_LENGTH-1:0] pc_next;
  logic                       active;

  assign tgt_aligned = {br_target[PC_WIDTH_LENGTH-1:2], 2'b00};
  assign active      = (state != BOOT);

  always_comb begin
    pc_next = pc_out;
    case (state)
      RUN: begin
        if (br_taken) begin
          if (imem_ready) pc_next = tgt_aligned;
        end else if (!stall && imem_ready) begin
          pc_next = pc_out + PC_WIDTH_LENGTH'(INSTR_BYTES);
        end
      end
      REDIR: begin
        // A fresh branch arriving with imem_ready bypasses the stale tgt_q.
        if (imem_ready) pc_next = br_taken ? tgt_aligned : tgt_q;
      end
      default: pc_next = pc_out;
    endcase
  end

  pc_ctrl_pc #(
    .W            (PC_WIDTH_LENGTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk   (clk),
    .rst   (rst),
    .pc_in (pc_next),
    .pc_q  (pc_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      tgt_q <= '0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (br_taken && !imem_ready) begin
            tgt_q <= tgt_aligned;
            state <= REDIR;
          end
        end
        REDIR: begin
          if (br_taken) tgt_q <= tgt_aligned;
          if (imem_ready) state <= RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign fetch_req   = active;
  assign if_valid    = (state == RUN) && imem_ready && !br_taken;
  assign flush_ifid  = br_taken && active && !rst;
  assign flush_idex  = br_taken && active && !rst;
  assign br_misalign = br_taken && (|br_target[1:0]) && active;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed table-driven bench for pc_ctrl plus a bounded first-fetch sequence.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, imem_ready;
  logic [31:0] br_target;
  logic [31:0] pc_out;
  logic        fetch_req, if_valid, flush_ifid, flush_idex, br_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_ready  (imem_ready),
    .pc_out      (pc_out),
    .fetch_req   (fetch_req),
    .if_valid    (if_valid),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .br_misalign (br_misalign)
  );

  typedef struct {
    logic        rst, stall, br, rdy;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_fr, e_iv, e_fl, e_mis;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic rd, input logic [31:0] pc, input logic fr,
                     input logic iv, input logic fl, input logic mis);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.rdy = rd;
    v.e_pc = pc; v.e_fr = fr; v.e_iv = iv; v.e_fl = fl; v.e_mis = mis;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; br_taken = v.br; br_target = v.tgt; imem_ready = v.rdy;
  endtask

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; imem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    //   rst stall br  target        rdy pc            fr iv fl mis
    add(1, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 0);  // 0 reset held
    add(0, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 0);  // 1 BOOT
    add(0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 0, 0);  // 2 RUN pc0
    add(0, 0, 0, 32'h0,        1, 32'h4,        1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h8,        1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hC,        1, 1, 0, 0);
    add(0, 1, 0, 32'h0,        1, 32'h10,       1, 1, 0, 0);  // 6 stall
    add(0, 1, 0, 32'h0,        1, 32'h10,       1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h10,       1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h14,       1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h18,       1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h1C,       1, 1, 0, 0);
    add(0, 0, 1, 32'h100,      1, 32'h20,       1, 0, 1, 0);  // 12 branch, ready
    add(0, 0, 0, 32'h0,        1, 32'h100,      1, 1, 0, 0);
    add(0, 0, 1, 32'h200,      0, 32'h104,      1, 0, 1, 0);  // 14 branch, not ready
    add(0, 0, 0, 32'h0,        0, 32'h104,      1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        0, 32'h104,      1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h104,      1, 0, 0, 0);  // 17 ready in REDIR
    add(0, 0, 0, 32'h0,        1, 32'h200,      1, 1, 0, 0);
    add(0, 0, 1, 32'h200,      0, 32'h204,      1, 0, 1, 0);  // 19 into REDIR
    add(0, 0, 1, 32'h300,      0, 32'h204,      1, 0, 1, 0);  // 20 latest target wins
    add(0, 1, 0, 32'h0,        0, 32'h204,      1, 0, 0, 0);  // 21 stall ignored
    add(0, 0, 0, 32'h0,        1, 32'h204,      1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h300,      1, 1, 0, 0);
    add(0, 0, 1, 32'h103,      1, 32'h304,      1, 0, 1, 1);  // 24 misaligned
    add(0, 0, 0, 32'h0,        1, 32'h100,      1, 1, 0, 0);
    add(0, 1, 1, 32'h400,      1, 32'h104,      1, 0, 1, 0);  // 26 branch beats stall
    add(0, 0, 0, 32'h0,        0, 32'h400,      1, 0, 0, 0);  // 27 imem wait
    add(0, 0, 0, 32'h0,        1, 32'h400,      1, 1, 0, 0);
    add(0, 0, 1, 32'h500,      0, 32'h404,      1, 0, 1, 0);  // 29 into REDIR
    add(0, 0, 1, 32'h600,      1, 32'h404,      1, 0, 1, 0);  // 30 new br + ready
    add(0, 0, 0, 32'h0,        1, 32'h600,      1, 1, 0, 0);
    add(0, 0, 1, 32'h700,      0, 32'h604,      1, 0, 1, 0);  // 32 into REDIR
    add(1, 0, 0, 32'h0,        0, 32'h604,      1, 0, 0, 0);  // 33 reset in REDIR
    add(0, 0, 1, 32'h803,      1, 32'h0,        0, 0, 0, 0);  // 34 BOOT ignores br
    add(0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 0, 0);
    add(0, 0, 1, 32'hFFFF_FFF8, 1, 32'h4,       1, 0, 1, 0);  // 36 near top
    add(0, 0, 0, 32'h0,        1, 32'hFFFF_FFF8, 1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 1, 0, 0);
    add(0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 0, 0);  // 39 wrapped

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      check("pc_out",      i, pc_out,             tbl[i].e_pc);
      check("fetch_req",   i, 32'(fetch_req),     32'(tbl[i].e_fr));
      check("if_valid",    i, 32'(if_valid),      32'(tbl[i].e_iv));
      check("flush_ifid",  i, 32'(flush_ifid),    32'(tbl[i].e_fl));
      check("flush_idex",  i, 32'(flush_idex),    32'(tbl[i].e_fl));
      check("br_misalign", i, 32'(br_misalign),   32'(tbl[i].e_mis));
      @(posedge clk); #1;
    end

    // First valid fetch after reset release, bounded wait.
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; imem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 1;
    #2;
    while (!if_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
      #2;
    end
    check("first_valid_cycle", 100, 32'(n), 32'd2);
    check("first_valid_pc",    101, pc_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-stage controller for the 5-stage RISC-V pipeline. It owns and sequences the program counter: sequential advance, load-use stall hold, taken-branch/jump redirect from EX, and waiting on a slow instruction memory. It drives the fetch address to instruction memory, generates IF/ID and ID/EX flushes, and marks which fetched words are valid.

## Interface
Parameters:
- PC_WIDTH_LENGTH, 32, PC and target width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- INSTR_BYTES, 4, sequential PC increment

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset; synchronous and active-high
- stall  input  1  load-use stall from hazard unit; hold PC
- br_taken  input  1  EX-stage taken branch/jump, single-cycle pulse
- br_target  input  PC_WIDTH_LENGTH  redirect address, valid with br_taken
- imem_ready  input  1  instruction memory has data for pc_out this cycle
- pc_out  output  PC_WIDTH_LENGTH  current fetch address (registered)
- fetch_req  output  1  fetch request to instruction memory
- if_valid  output  1  word returned this cycle is a valid instruction
- flush_ifid  output  1  clear IF/ID register
- flush_idex  output  1  clear ID/EX register
- br_misalign  output  1  one-cycle pulse: br_target[1:0] was nonzero

## Operation
- States: BOOT, RUN, REDIR. Reset enters BOOT.
- BOOT: fetch_req=0, if_valid=0, pc_out=RESET_VECTOR; next cycle RUN unconditionally (br_taken ignored in BOOT).
- RUN: fetch_req=1. Priority br_taken > stall > imem_ready low > advance.
  - br_taken & imem_ready: pc_out <= target; stay RUN.
  - br_taken & ~imem_ready: outstanding fetch must be dropped; target latched in tgt_q; go REDIR; pc_out held.
  - stall (no br_taken): pc_out held.
  - ~imem_ready: pc_out held.
  - else: pc_out <= pc_out + INSTR_BYTES, modulo 2^PC_WIDTH_LENGTH (0xFFFF_FFFC wraps to 0x0000_0000).
- REDIR: fetch_req=1, if_valid=0. When imem_ready: pc_out <= tgt_q, go RUN. New br_taken in REDIR overwrites tgt_q (latest wins); if it coincides with imem_ready, pc_out <= new target directly.
- if_valid = (state==RUN) & imem_ready & ~br_taken.
- flush_ifid = flush_idex = br_taken & (state!=BOOT) & ~rst.
- Target: bits [1:0] forced to 0 before use; br_misalign = br_taken & |br_target[1:0] & (state!=BOOT).
- stall never blocks a redirect; stall in REDIR has no effect.

## Timing
- Reset values: pc_out=RESET_VECTOR, state=BOOT, tgt_q=0, fetch_req=0, if_valid=0, flushes=0, br_misalign=0.
- rst sampled high mid-operation overrides everything: next cycle BOOT, pending redirect discarded.
- pc_out registered; fetch_req, if_valid, flush_*, br_misalign combinational from state and inputs, same cycle.
- Redirect latency: target on pc_out the cycle after br_taken when imem_ready=1; otherwise the cycle after the first imem_ready in REDIR.
- First valid fetch of RESET_VECTOR: earliest 2nd cycle after rst release.

## Structure
- Shared package: state encoding (BOOT/RUN/REDIR), INSTR_BYTES and RESET_VECTOR defaults, PC width constant.
- One sub-module: the existing `pc` register, its pc_in driven by this block's next-PC mux; state machine, tgt_q and output logic local.

## Test plan
- Reset release, imem_ready=1: pc_out 0,0,4,8,0xC; fetch_req 0 in BOOT; if_valid first high in RUN at pc 0.
- stall high 2 cycles at pc 0x10: pc_out stays 0x10, then 0x14; no flushes.
- br_taken target 0x100 at pc 0x20, imem_ready=1: flush_ifid=flush_idex=1 that cycle, if_valid=0, next pc_out 0x100.
- br_taken target 0x200 with imem_ready=0 for 3 cycles: pc_out held, if_valid=0 throughout, pc_out=0x200 the cycle after imem_ready rises.
- In REDIR, second br_taken target 0x300: pc_out becomes 0x300, never 0x200; br_target 0x103 gives br_misalign=1, pc_out 0x100.
- pc_out 0xFFFF_FFFC advance -> 0x0; rst during REDIR -> pc_out=RESET_VECTOR, state BOOT.
